// File: rtl/jtgng_ioctl_sdram_loader.sv
// ROM download consumer: packs byte-wide ioctl writes into 16-bit words,
// buffers them in a small FIFO and issues SDRAM writes under req/ack.
module jtgng_ioctl_sdram_loader #(
  parameter int AW         = 22,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic          clk_rom,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_be,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic          dwnld_busy,
  output logic          dwnld_done,
  output logic          overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_n;

  // download edge detection
  logic dl_last;
  logic dl_fall, dl_rise;

  // pending (partially packed) word
  logic          pend_valid, pend_valid_n;
  logic [AW-2:0] pend_addr, pend_addr_n;
  logic [15:0]   pend_data, pend_data_n;
  logic [1:0]    pend_be, pend_be_n;

  // incoming byte decoded into word form
  logic          wr_acc;
  logic          byte_lane;
  logic [AW-2:0] byte_addr;
  logic [1:0]    byte_be;
  logic [15:0]   byte_word;
  logic          merge;
  logic [1:0]    merged_be;
  logic [15:0]   merged_data;

  // push request from the packer
  logic          push, push_ok;
  logic [AW-2:0] push_addr;
  logic [15:0]   push_data;
  logic [1:0]    push_be;

  // FIFO storage and bookkeeping
  logic [AW-2:0]         fifo_addr [DEPTH];
  logic [15:0]           fifo_data [DEPTH];
  logic [1:0]            fifo_be   [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  fifo_empty, fifo_full;

  // write FSM controls
  logic load_out, pop;
  logic busy_n;

  // Packer: merge the byte into the pending word or push and restart
  always_comb begin
    wr_acc      = ioctl_wr & downloading;
    dl_fall     = dl_last & ~downloading;
    dl_rise     = ~dl_last & downloading;
    byte_lane   = ioctl_addr[0];
    byte_addr   = ioctl_addr[AW-1:1];
    byte_be     = byte_lane ? 2'b10 : 2'b01;
    byte_word   = byte_lane ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
    merge       = pend_valid && (pend_addr == byte_addr) && ((pend_be & byte_be) == 2'b00);
    // the unset lane of the pending word is always zero, so OR merges cleanly
    merged_be   = pend_be | byte_be;
    merged_data = pend_data | byte_word;

    push         = 1'b0;
    push_addr    = pend_addr;
    push_data    = pend_data;
    push_be      = pend_be;
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    pend_data_n  = pend_data;
    pend_be_n    = pend_be;

    if (wr_acc) begin
      if (merge) begin
        pend_data_n = merged_data;
        pend_be_n   = merged_be;
        if (merged_be == 2'b11) begin
          push         = 1'b1;
          push_data    = merged_data;
          push_be      = merged_be;
          pend_valid_n = 1'b0;
        end
      end else begin
        // a non-mergeable byte flushes whatever is pending as a partial word
        push         = pend_valid;
        pend_valid_n = 1'b1;
        pend_addr_n  = byte_addr;
        pend_data_n  = byte_word;
        pend_be_n    = byte_be;
      end
    end else if (dl_fall && pend_valid) begin
      push         = 1'b1;
      pend_valid_n = 1'b0;
    end
  end

  // Pending word register
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      pend_be    <= '0;
    end else begin
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
      pend_data  <= pend_data_n;
      pend_be    <= pend_be_n;
    end
  end

  // FIFO status; a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_FULL);
    push_ok    = push && (!fifo_full || pop);
  end

  // FIFO storage writes (data only, no reset needed)
  always_ff @(posedge clk_rom) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Write FSM state register
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Write FSM next state; head stays in the FIFO until acked
  always_comb begin
    state_n  = state;
    load_out = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_out = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          pop     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // SDRAM request outputs, held stable while waiting for ack
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
      sdram_be   <= '0;
    end else if (load_out) begin
      sdram_req  <= 1'b1;
      sdram_addr <= fifo_addr[rd_ptr];
      sdram_din  <= fifo_data[rd_ptr];
      sdram_be   <= fifo_be[rd_ptr];
    end else if (pop) begin
      sdram_req  <= 1'b0;
    end
  end

  // Busy is anything still in flight; done marks the cycle busy first reads low
  always_comb begin
    busy_n = downloading | pend_valid | ~fifo_empty | sdram_req;
  end

  // Status registers: busy/done, download edge tracking and sticky overflow
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dwnld_busy <= 1'b0;
      dwnld_done <= 1'b0;
      dl_last    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dwnld_busy <= busy_n;
      dwnld_done <= dwnld_busy & ~busy_n;
      dl_last    <= downloading;
      if (push && !push_ok) overflow <= 1'b1;
      else if (dl_rise)     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtgng_ioctl_sdram_loader.sv
// Directed bench for jtgng_ioctl_sdram_loader with hand-computed expectations.
module tb_jtgng_ioctl_sdram_loader;

  localparam int AW = 22;

  logic          clk_rom = 1'b0;
  logic          rst = 1'b1;
  logic          downloading = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic          ioctl_wr = 1'b0;
  logic [AW-2:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_be;
  logic          sdram_req;
  logic          sdram_ack = 1'b0;
  logic          dwnld_busy;
  logic          dwnld_done;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  jtgng_ioctl_sdram_loader #(.AW(AW), .DEPTH_LOG2(2)) dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_be    (sdram_be),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .dwnld_busy  (dwnld_busy),
    .dwnld_done  (dwnld_done),
    .overflow    (overflow)
  );

  // 10 ns clock
  always #5 clk_rom = ~clk_rom;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [AW-2:0] ea,
                          input logic [15:0] ed, input logic [1:0] eb);
    int n = 0;
    while (!sdram_req && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"},  32'(sdram_req),  32'd1);
    check({tag, "_addr"}, 32'(sdram_addr), 32'(ea));
    check({tag, "_din"},  32'(sdram_din),  32'(ed));
    check({tag, "_be"},   32'(sdram_be),   32'(eb));
  endtask

  task automatic do_ack(input string tag);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check({tag, "_ackdrop"}, 32'(sdram_req), 32'd0);
  endtask

  // Watch busy/done for a while after the last write completes
  task automatic watch_done(input string tag);
    int done_cnt = 0;
    logic busy_prev = dwnld_busy;
    logic busy_at_done = 1'b1;
    logic prev_at_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dwnld_done) begin
        done_cnt++;
        busy_at_done = dwnld_busy;
        prev_at_done = busy_prev;
      end
      busy_prev = dwnld_busy;
    end
    check({tag, "_done_cnt"},  32'(done_cnt),     32'd1);
    check({tag, "_done_busy"}, 32'(busy_at_done), 32'd0);
    check({tag, "_done_prev"}, 32'(prev_at_done), 32'd1);
    check({tag, "_busy_end"},  32'(dwnld_busy),   32'd0);
  endtask

  initial begin
    int req_seen;
    int done_seen;

    // 1. Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      downloading = 1'($urandom);
      ioctl_addr  = AW'($urandom);
      ioctl_data  = 8'($urandom);
      ioctl_wr    = 1'($urandom);
      sdram_ack   = 1'($urandom);
      tick();
    end
    check("rst_req",  32'(sdram_req),  32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_din",  32'(sdram_din),  32'd0);
    check("rst_be",   32'(sdram_be),   32'd0);
    check("rst_busy", 32'(dwnld_busy), 32'd0);
    check("rst_done", 32'(dwnld_done), 32'd0);
    check("rst_ovf",  32'(overflow),   32'd0);
    downloading = 1'b0;
    ioctl_wr    = 1'b0;
    sdram_ack   = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wr_byte(22'd0, 8'h11);
    wr_byte(22'd1, 8'h22);
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sdram_req) req_seen++;
    end
    check("t1_no_req",  32'(req_seen),   32'd0);
    check("t1_no_busy", 32'(dwnld_busy), 32'd0);

    // 2. Word pair with latency check
    downloading = 1'b1;
    tick();
    wr_byte(22'd0, 8'h34);
    wr_byte(22'd1, 8'h12);
    check("t2_lat1", 32'(sdram_req), 32'd0);
    tick();
    check("t2_lat2", 32'(sdram_req), 32'd1);
    wait_req("t2", 21'd0, 16'h1234, 2'b11);
    check("t2_busy", 32'(dwnld_busy), 32'd1);
    do_ack("t2");

    // 3. Odd length, flush on end of transfer, done pulse
    wr_byte(22'd0, 8'hAA);
    wr_byte(22'd1, 8'hBB);
    wr_byte(22'd2, 8'hCC);
    downloading = 1'b0;
    tick();
    wait_req("t3w0", 21'd0, 16'hBBAA, 2'b11);
    do_ack("t3w0");
    wait_req("t3w1", 21'd1, 16'h00CC, 2'b01);
    do_ack("t3w1");
    watch_done("t3");

    // 4. Sparse addresses
    downloading = 1'b1;
    tick();
    wr_byte(22'd5, 8'h55);
    wr_byte(22'd8, 8'h66);
    downloading = 1'b0;
    tick();
    wait_req("t4w0", 21'd2, 16'h5500, 2'b10);
    do_ack("t4w0");
    wait_req("t4w1", 21'd4, 16'h0066, 2'b01);
    do_ack("t4w1");
    watch_done("t4");

    // 5. Overflow under back-pressure
    downloading = 1'b1;
    tick();
    for (int a = 0; a < 12; a++) wr_byte(AW'(a), 8'(a));
    check("t5_ovf",      32'(overflow),   32'd1);
    check("t5_hold_din", 32'(sdram_din),  32'h0100);
    downloading = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("t5w%0d", k), 21'(k), {8'(2*k+1), 8'(2*k)}, 2'b11);
      do_ack($sformatf("t5w%0d", k));
    end
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_req) req_seen++;
    end
    check("t5_no_extra", 32'(req_seen), 32'd0);
    check("t5_ovf_held", 32'(overflow), 32'd1);
    downloading = 1'b1;
    tick();
    check("t5_ovf_clr", 32'(overflow), 32'd0);

    // 6. Reset during an outstanding request
    for (int a = 0; a < 6; a++) wr_byte(AW'(a), 8'(a + 8'h40));
    check("t6_req_pre",  32'(sdram_req),  32'd1);
    check("t6_busy_pre", 32'(dwnld_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_req_async",  32'(sdram_req),  32'd0);
    check("t6_busy_async", 32'(dwnld_busy), 32'd0);
    check("t6_done_async", 32'(dwnld_done), 32'd0);
    downloading = 1'b0;
    tick();
    rst = 1'b0;
    req_seen  = 0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_req)  req_seen++;
      if (dwnld_done) done_seen++;
    end
    check("t6_no_req",  32'(req_seen),  32'd0);
    check("t6_no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtgng_ioctl_sdram_loader.md
# jtgng_ioctl_sdram_loader

Consumer end of the ROM download stream: takes the byte-wide ioctl write strobes produced by the SD-card loader (`ioctl_addr`/`ioctl_data`/`ioctl_wr`/`downloading`) and turns them into 16-bit SDRAM write requests under a req/ack handshake. It sits between the loader and the SDRAM controller in the `clk_rom` domain. It packs byte pairs into words, buffers them in a small FIFO against SDRAM back-pressure, and reports completion.

## Interface
Parameters:
- `AW`, 22: ioctl byte-address width; SDRAM word address is `AW-1` bits.
- `DEPTH_LOG2`, 2: FIFO depth is 2^`DEPTH_LOG2` words (default 4).

Ports:
- `clk_rom`  in  1: single clock; everything is registered on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `downloading`  in  1: high for the whole ROM transfer.
- `ioctl_addr`  in  AW: byte address of the current write.
- `ioctl_data`  in  8: byte value.
- `ioctl_wr`  in  1: one-cycle write strobe.
  - Strobes are ignored while `downloading`=0.
- `sdram_addr`  out  AW-1: word address, equal to byte address >> 1.
- `sdram_din`  out  16: write data.
  - Even byte goes on [7:0], odd byte on [15:8].
- `sdram_be`  out  2: byte enables, active-high.
  - Bit 0 is lane [7:0]; bit 1 is lane [15:8].
- `sdram_req`  out  1: write request.
- `sdram_ack`  in  1: one-cycle acknowledge from the SDRAM controller.
- `dwnld_busy`  out  1: asserted while any data remains to be written.
- `dwnld_done`  out  1: one-cycle pulse on the falling edge of `dwnld_busy`.
- `overflow`  out  1: sticky flag; set when a word was dropped because the FIFO was full.

## Operation
Packer: a single pending-word register holds `pend_valid`, `pend_addr`, `pend_data[15:0]` and `pend_be[1:0]`. On each accepted `ioctl_wr`:
- **Merge case:** `pend_valid`, `pend_addr == ioctl_addr>>1`, and the byte's lane is not yet set in `pend_be`.
  - Merge the byte into its lane.
  - If the merged `be` is 2'b11, push the word and clear `pend_valid`.
- **Otherwise:**
  - If `pend_valid`, push the pending word as a partial word.
  - Load the new byte into pending: `pend_be` has only its lane set, the other lane's data is 0.
- At most one push happens per cycle.

End of transfer: on the falling edge of `downloading`, if `pend_valid`, push pending and clear it.

FIFO:
- `2^DEPTH_LOG2` entries of {addr, data, be}.
- A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- A refused push drops the word and sets `overflow`.
- Push and pop in the same cycle leave the count unchanged.

Write FSM:
- **IDLE:** if the FIFO is non-empty, register the FIFO head onto `sdram_addr`/`sdram_din`/`sdram_be`, set `sdram_req`=1, and go to REQ.
- **REQ:** outputs are held stable. When `sdram_ack`=1, clear `sdram_req`, pop the FIFO head, and go to IDLE.
- Every request is followed by at least one idle cycle with `sdram_req`=0.
- `sdram_ack` is ignored in IDLE.
- The head entry stays in the FIFO until it is acked, so FIFO capacity includes the in-flight word.

Status outputs:
- `dwnld_busy` = `downloading` | `pend_valid` | FIFO non-empty | `sdram_req`, registered.
- `overflow` is cleared on the rising edge of `downloading`.

## Timing
Reset values:
- `sdram_req`=0, `sdram_addr`=0, `sdram_din`=0, `sdram_be`=0.
- `dwnld_busy`=0, `dwnld_done`=0, `overflow`=0.
- FIFO empty, `pend_valid`=0, FSM in IDLE.
- Reset mid-operation discards all pending and buffered data immediately (asynchronous). No ack is awaited.

Latency:
- A word completed by the `ioctl_wr` sampled at edge N is in the FIFO after edge N.
- `sdram_req` is high after edge N+1.
- When the FIFO is empty and the SDRAM is idle, the ioctl_wr-to-`sdram_req` latency is therefore 2 cycles.

Flush on end of transfer: the pending word is pushed at the edge that samples `downloading` low, where it was high at the previous edge.
- If an `ioctl_wr` coincides with that edge, it is ignored (gated by `downloading`).

Throughput: one word per 2 cycles minimum, when ack arrives in the first REQ cycle.

Back-pressure: the ack wait is unbounded, and the loader is never stalled.

`dwnld_done`: high for exactly one cycle, the cycle after `dwnld_busy` goes 1→0. It is not generated by reset.

Address wrap: there is no wrap handling. `ioctl_addr` is taken as-is, and `sdram_addr` = `ioctl_addr[AW-1:1]`.

## Test plan
1. **Reset:** hold `rst`=1 with random inputs → all outputs 0. Release `rst`, keep `downloading`=0, and strobe `ioctl_wr` → no `sdram_req`.
2. **Word pair:** `downloading`=1; write 0x34@0, then 0x12@1 → `sdram_req` 2 cycles after the second strobe with addr 0, din 0x1234, be 2'b11. Ack → `sdram_req` low next cycle.
3. **Odd length:** write 0xAA@0, 0xBB@1, 0xCC@2, then drop `downloading` → two requests:
   - addr 0, din 0xBBAA, be 11;
   - addr 1, din 0x00CC, be 01.
   Then `dwnld_busy` falls and `dwnld_done` pulses once.
4. **Sparse addresses:** write 0x55@5, then 0x66@8, then end → two requests:
   - addr 2, din 0x5500, be 10;
   - addr 4, din 0x0066, be 01.
5. **Overflow:** hold `sdram_ack`=0 and write bytes 0..11 (values = address) → 4 words accepted (addr 0..3), words 4 and 5 dropped, `overflow`=1. Then ack each request → exactly 4 writes: din 0x0100, 0x0302, 0x0504, 0x0706. `overflow` stays 1 until the next `downloading` rise.
6. **Reset during request:** `sdram_req`=1 and FIFO holding 3 words; pulse `rst` → `sdram_req`, `dwnld_busy` and `dwnld_done` go 0 asynchronously, and no further request follows.
